// File: rtl/ebox_err_capture.sv
// ebox_err_capture: edge-detects EBOX error sources, keeps sticky bits, captures the first error
// and requests an APR interrupt through a req/ack handshake.
module ebox_err_capture #(
    parameter int NSRC = 5,
    parameter int VAW  = 23,
    parameter int CNTW = 8,
    localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            eboxClk,
    input  logic            eboxReset_n,
    input  logic [NSRC-1:0] errIn,
    input  logic [NSRC-1:0] errMask,
    input  logic [VAW-1:0]  vmaIn,
    input  logic            errClr,
    input  logic [NSRC-1:0] errClrSel,
    input  logic            intAck,
    output logic            anyEboxError,
    output logic [NSRC-1:0] errSticky,
    output logic            firstValid,
    output logic [SW-1:0]   firstSrc,
    output logic [VAW-1:0]  firstVMA,
    output logic [CNTW-1:0] errCount,
    output logic            errOverflow,
    output logic            intReq
);
    typedef enum logic [1:0] {IDLE, PEND, ACKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [NSRC-1:0] r_prev, r_sticky, w_rise, w_sticky_nxt;
    logic [SW-1:0]   r_src, w_low;
    logic [VAW-1:0]  r_vma;
    logic [CNTW-1:0] r_cnt;
    logic            r_any, r_valid, r_ovf, w_evt, w_release;

    assign w_rise       = errIn & ~r_prev & ~errMask;
    assign w_evt        = |w_rise;
    assign w_sticky_nxt = w_rise | (r_sticky & ~({NSRC{errClr}} & errClrSel));
    assign w_release    = (r_state == ACKED) && (w_state_nxt == IDLE);

    always_comb begin
        w_low = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_rise[i]) w_low = SW'(i);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_evt ? PEND : IDLE;
            PEND:    w_state_nxt = (intAck && !w_evt) ? ACKED : PEND;
            ACKED:   w_state_nxt = w_evt ? PEND : (errClr && w_sticky_nxt == '0) ? IDLE : ACKED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // History tracks the lines even in reset so a line held high across reset release does not fire.
    always_ff @(posedge eboxClk) r_prev <= errIn;

    always_ff @(posedge eboxClk) begin
        if (!eboxReset_n) begin
            r_state  <= IDLE;
            r_sticky <= '0;
            r_any    <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_src    <= '0;
            r_vma    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sticky <= w_sticky_nxt;
            r_any    <= |w_sticky_nxt;
            if (w_evt && !(&r_cnt)) r_cnt <= r_cnt + CNTW'(1);
            if (w_release) begin
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_evt) begin
                if (r_valid) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_src   <= w_low;
                    r_vma   <= vmaIn;
                end
            end
        end
    end

    assign anyEboxError = r_any;
    assign errSticky    = r_sticky;
    assign firstValid   = r_valid;
    assign firstSrc     = r_src;
    assign firstVMA     = r_vma;
    assign errCount     = r_cnt;
    assign errOverflow  = r_ovf;
    assign intReq       = (r_state == PEND);
endmodule

// File: tb/tb_ebox_err_capture.sv
// tb_ebox_err_capture: directed vectors against a default instance and a 2-bit-counter instance.
module tb_ebox_err_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  err_in, err_mask, err_clr_sel;
    logic [22:0] vma_in;
    logic        err_clr, int_ack;
    logic        any_err, first_valid, ovf, int_req;
    logic [4:0]  sticky;
    logic [2:0]  first_src;
    logic [22:0] first_vma;
    logic [7:0]  cnt;
    logic        s_any, s_valid, s_ovf, s_req;
    logic [4:0]  s_sticky;
    logic [2:0]  s_src;
    logic [22:0] s_vma;
    logic [1:0]  s_cnt;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ebox_err_capture u_dut (
        .eboxClk(clk), .eboxReset_n(rst_n), .errIn(err_in), .errMask(err_mask),
        .vmaIn(vma_in), .errClr(err_clr), .errClrSel(err_clr_sel), .intAck(int_ack),
        .anyEboxError(any_err), .errSticky(sticky), .firstValid(first_valid),
        .firstSrc(first_src), .firstVMA(first_vma), .errCount(cnt),
        .errOverflow(ovf), .intReq(int_req)
    );

    ebox_err_capture #(.CNTW(2)) u_sat (
        .eboxClk(clk), .eboxReset_n(rst_n), .errIn(err_in), .errMask(err_mask),
        .vmaIn(vma_in), .errClr(err_clr), .errClrSel(err_clr_sel), .intAck(int_ack),
        .anyEboxError(s_any), .errSticky(s_sticky), .firstValid(s_valid),
        .firstSrc(s_src), .firstVMA(s_vma), .errCount(s_cnt),
        .errOverflow(s_ovf), .intReq(s_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; err_in = 5'h1F; err_mask = '0; err_clr_sel = '0;
        vma_in = '0; err_clr = 1'b0; int_ack = 1'b0;
        #1;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_sticky", 32'(sticky), 0);
        check("rst_any", 32'(any_err), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_req", 32'(int_req), 0);
        check("rst_valid", 32'(first_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        err_in = '0;
        step();
        check("fall_no_evt", 32'(cnt), 0);

        err_in = 5'b01000; vma_in = 23'h012345;
        step();
        check("single_sticky", 32'(sticky), 32'h08);
        check("single_src", 32'(first_src), 3);
        check("single_vma", 32'(first_vma), 32'h012345);
        check("single_cnt", 32'(cnt), 1);
        check("single_req", 32'(int_req), 1);
        check("single_any", 32'(any_err), 1);
        check("single_valid", 32'(first_valid), 1);
        vma_in = 23'h7FFFFF;
        step();
        check("held_no_evt", 32'(cnt), 1);

        err_in = '0; int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("ack_req", 32'(int_req), 0);

        err_in = 5'b00001;
        step();
        check("reevt_req", 32'(int_req), 1);
        check("reevt_ovf", 32'(ovf), 1);
        check("reevt_src", 32'(first_src), 3);
        check("reevt_vma", 32'(first_vma), 32'h012345);
        check("reevt_sticky", 32'(sticky), 32'h09);
        check("reevt_cnt", 32'(cnt), 2);

        err_in = '0; int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        err_clr = 1'b1; err_clr_sel = 5'h1F;
        step();
        err_clr = 1'b0;
        check("clr_valid", 32'(first_valid), 0);
        check("clr_ovf", 32'(ovf), 0);
        check("clr_sticky", 32'(sticky), 0);
        check("clr_any", 32'(any_err), 0);
        check("clr_cnt", 32'(cnt), 2);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("idle_ack_ignored", 32'(int_req), 0);

        err_in = 5'b10010; vma_in = 23'h000ABC;
        step();
        check("simul_src", 32'(first_src), 1);
        check("simul_cnt", 32'(cnt), 3);
        check("simul_sticky", 32'(sticky), 32'h12);
        check("simul_vma", 32'(first_vma), 32'h000ABC);

        err_in = '0; err_clr = 1'b1; err_clr_sel = 5'b00010;
        step();
        err_clr = 1'b0;
        check("pend_clr_sticky", 32'(sticky), 32'h10);
        check("pend_clr_req", 32'(int_req), 1);

        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        err_mask = 5'b00100; err_in = 5'b00100;
        step();
        check("mask_sticky", 32'(sticky), 32'h10);
        check("mask_cnt", 32'(cnt), 3);
        err_mask = '0;
        step();
        check("unmask_cnt", 32'(cnt), 3);
        check("unmask_req", 32'(int_req), 0);

        err_in = 5'b00101; err_clr = 1'b1; err_clr_sel = 5'h1F;
        step();
        err_clr = 1'b0;
        check("race_sticky", 32'(sticky), 32'h01);
        check("race_req", 32'(int_req), 1);
        check("race_cnt", 32'(cnt), 4);
        check("race_src", 32'(first_src), 1);
        check("sat_cnt4", 32'(s_cnt), 3);

        err_in = '0;
        step();
        err_in = 5'b10000;
        step();
        check("cnt5", 32'(cnt), 5);
        check("sat_cnt5", 32'(s_cnt), 3);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_req", 32'(int_req), 0);
        check("abort_cnt", 32'(cnt), 0);
        check("abort_sticky", 32'(sticky), 0);
        step();
        check("post_rst_held", 32'(cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
